// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) types and helpers: rail struct, FSM states, bit
// classification and value-to-dual-rail packing.
package ncl_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    WAITKI,
    DATA,
    RTZ
  } ncl_state_t;

  localparam int DR_MAX_W = 64;

  typedef struct packed {
    logic [DR_MAX_W-1:0] r1;
    logic [DR_MAX_W-1:0] r0;
  } dr_vec_t;

  function automatic logic dr_is_data(input logic r1, input logic r0);
    return r1 ^ r0;
  endfunction

  function automatic logic dr_is_null(input logic r1, input logic r0);
    return ~(r1 | r0);
  endfunction

  // Bits at or above w stay NULL so the caller can truncate freely.
  function automatic dr_vec_t dr_pack(input logic [DR_MAX_W-1:0] v, input int w);
    dr_vec_t res;
    res = '0;
    for (int unsigned i = 0; i < DR_MAX_W; i++) begin
      if (int'(i) < w) begin
        res.r1[i] = v[i];
        res.r0[i] = ~v[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ncl_dr_detect.sv
// Combinational completion/null/illegal detection for a dual-rail vector.
module ncl_dr_detect
  import ncl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r0,
  output logic         complete,
  output logic         is_null,
  output logic         illegal
);

  dual_rail_logic bit_v;

  always_comb begin
    complete = 1'b1;
    is_null  = 1'b1;
    illegal  = 1'b0;
    bit_v    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      bit_v    = '{rail1: r1[i], rail0: r0[i]};
      complete = complete & dr_is_data(bit_v.rail1, bit_v.rail0);
      is_null  = is_null & dr_is_null(bit_v.rail1, bit_v.rail0);
      illegal  = illegal | (bit_v.rail1 & bit_v.rail0);
    end
  end

endmodule

// File: rtl/ncl_mult_seq.sv
// Clocked dual-rail shift-add multiplier with four-phase DATA/NULL handshakes;
// one partial product per clock, optional two's-complement operation.
module ncl_mult_seq
  import ncl_pkg::*;
#(
  parameter int A_W    = 3,
  parameter int B_W    = 3,
  parameter int SIGNED = 0,
  localparam int P_W   = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a_r1,
  input  logic [A_W-1:0] a_r0,
  input  logic [B_W-1:0] b_r1,
  input  logic [B_W-1:0] b_r0,
  output logic           ko,
  output logic [P_W-1:0] p_r1,
  output logic [P_W-1:0] p_r0,
  input  logic           ki,
  output logic           err
);

  localparam int CW = (B_W > 1) ? $clog2(B_W) : 1;

  ncl_state_t     state, state_nxt;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [CW-1:0]  cnt;
  logic [P_W-1:0] acc, ext, pp;
  logic           a_comp, a_null, a_ill;
  logic           b_comp, b_null, b_ill;
  logic           capture, last, p_load, p_clear, ko_set;
  dr_vec_t        pk;

  ncl_dr_detect #(.W(A_W)) u_det_a (
    .r1       (a_r1),
    .r0       (a_r0),
    .complete (a_comp),
    .is_null  (a_null),
    .illegal  (a_ill)
  );

  ncl_dr_detect #(.W(B_W)) u_det_b (
    .r1       (b_r1),
    .r0       (b_r0),
    .complete (b_comp),
    .is_null  (b_null),
    .illegal  (b_ill)
  );

  // Signed mode: the MSB of B carries weight -2^(B_W-1), hence the final subtract.
  always_comb begin
    ext  = (SIGNED != 0) ? {{B_W{a_q[A_W-1]}}, a_q} : {{B_W{1'b0}}, a_q};
    pp   = ext << cnt;
    last = (cnt == CW'(B_W - 1));
    pk   = dr_pack(DR_MAX_W'(acc), P_W);
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    p_load    = 1'b0;
    p_clear   = 1'b0;
    ko_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_comp && b_comp && !a_ill && !b_ill) begin
          capture   = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (last) state_nxt = WAITKI;
      end
      WAITKI: begin
        if (ki) begin
          p_load    = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (!ki) begin
          p_clear   = 1'b1;
          state_nxt = RTZ;
        end
      end
      RTZ: begin
        if (a_null && b_null) begin
          ko_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ko   <= 1'b1;
      p_r1 <= '0;
      p_r0 <= '0;
      err  <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      err <= err | a_ill | b_ill;
      if (capture) begin
        a_q <= a_r1;
        b_q <= b_r1;
        acc <= '0;
        cnt <= '0;
        ko  <= 1'b0;
      end
      if (state == MUL) begin
        if (b_q[cnt]) acc <= ((SIGNED != 0) && last) ? acc - pp : acc + pp;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (p_load) begin
        p_r1 <= P_W'(pk.r1);
        p_r0 <= P_W'(pk.r0);
      end
      if (p_clear) begin
        p_r1 <= '0;
        p_r0 <= '0;
      end
      if (ko_set) ko <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_mult_seq.sv
// Bench for ncl_mult_seq: an unsigned 3x3 and a signed 4x4 instance driven
// through directed handshakes, checked against an arithmetic scoreboard.
module tb_ncl_mult_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a0_r1, a0_r0, b0_r1, b0_r0;
  logic       ki0, ko0, err0;
  logic [5:0] p0_r1, p0_r0;
  logic [3:0] a1_r1, a1_r0, b1_r1, b1_r0;
  logic       ki1, ko1, err1;
  logic [7:0] p1_r1, p1_r0;

  int tests = 0;
  int fails = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  ncl_mult_seq #(.A_W(3), .B_W(3), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .a_r1(a0_r1), .a_r0(a0_r0), .b_r1(b0_r1), .b_r0(b0_r0),
    .ko(ko0), .p_r1(p0_r1), .p_r0(p0_r0), .ki(ki0), .err(err0)
  );

  ncl_mult_seq #(.A_W(4), .B_W(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .a_r1(a1_r1), .a_r0(a1_r0), .b_r1(b1_r1), .b_r0(b1_r0),
    .ko(ko1), .p_r1(p1_r1), .p_r0(p1_r0), .ki(ki1), .err(err1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic p_is_data(input int w);
    return (w == 0) ? ((p0_r1 ^ p0_r0) == 6'h3f) : ((p1_r1 ^ p1_r0) == 8'hff);
  endfunction

  function automatic logic p_is_null(input int w);
    return (w == 0) ? ((p0_r1 | p0_r0) == 6'h00) : ((p1_r1 | p1_r0) == 8'h00);
  endfunction

  function automatic int p_val(input int w);
    return (w == 0) ? int'(p0_r1) : int'(p1_r1);
  endfunction

  function automatic int p0_val(input int w);
    return (w == 0) ? int'(p0_r0) : int'(p1_r0);
  endfunction

  function automatic logic ko_of(input int w);
    return (w == 0) ? ko0 : ko1;
  endfunction

  function automatic logic err_of(input int w);
    return (w == 0) ? err0 : err1;
  endfunction

  task automatic drive(input int w, input int a, input int b);
    if (w == 0) begin
      a0_r1 = 3'(a); a0_r0 = ~3'(a); b0_r1 = 3'(b); b0_r0 = ~3'(b);
    end else begin
      a1_r1 = 4'(a); a1_r0 = ~4'(a); b1_r1 = 4'(b); b1_r0 = ~4'(b);
    end
  endtask

  task automatic drive_null(input int w);
    if (w == 0) begin
      a0_r1 = '0; a0_r0 = '0; b0_r1 = '0; b0_r0 = '0;
    end else begin
      a1_r1 = '0; a1_r0 = '0; b1_r1 = '0; b1_r0 = '0;
    end
  endtask

  task automatic set_ki(input int w, input logic v);
    if (w == 0) ki0 = v;
    else        ki1 = v;
  endtask

  task automatic wait_ko(input int w, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ko_of(w) != lvl && n < 40);
  endtask

  task automatic wait_data(input int w, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!p_is_data(w) && n < 40);
  endtask

  // One full four-phase transaction; lit < 0 means no hand literal to pin.
  task automatic run_op(input int w, input int a, input int b, input int bp, input int lit);
    int n;
    int bw;
    bw = (w == 0) ? 3 : 4;
    if (w == 0) q0.push_back((a * b) & 63);
    else        q1.push_back((a * b) & 255);
    set_ki(w, bp == 0);
    drive(w, a, b);
    wait_ko(w, 1'b0, n);
    chk("ko_fall_cycles", n, 1);
    if (bp > 0) begin
      repeat (bp) begin
        @(negedge clk);
        chk("p_null_backpressure", p_is_null(w), 1);
      end
      set_ki(w, 1'b1);
      wait_data(w, n);
      chk("ki_to_data_cycles", n, 1);
    end else begin
      wait_data(w, n);
      chk("capture_to_data_cycles", n, bw + 1);
    end
    if (lit >= 0) begin
      chk("p_r1_literal", p_val(w), lit);
      chk("p_r0_literal", p0_val(w), (~lit) & ((w == 0) ? 63 : 255));
    end
    drive_null(w);
    set_ki(w, 1'b0);
    @(negedge clk);
    chk("p_null_after_ki0", p_is_null(w), 1);
    chk("ko_low_in_rtz", ko_of(w), 0);
    @(negedge clk);
    chk("ko_rise", ko_of(w), 1);
  endtask

  // Scoreboard: every new DATA product must match the next expected value.
  logic prev0 = 1'b0, prev1 = 1'b0;
  int   hold0 = 0, hold1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      chk("p0_legal", ((p0_r1 & p0_r0) == 6'h00) && (p_is_null(0) || p_is_data(0)), 1);
      if (p_is_data(0)) begin
        if (!prev0) begin
          if (q0.size() == 0) chk("p0_unexpected_data", p_val(0), -1);
          else begin
            hold0 = q0.pop_front();
            chk("p0_product", p_val(0), hold0);
          end
        end else chk("p0_hold", p_val(0), hold0);
      end
      prev0 = p_is_data(0);

      chk("p1_legal", ((p1_r1 & p1_r0) == 8'h00) && (p_is_null(1) || p_is_data(1)), 1);
      if (p_is_data(1)) begin
        if (!prev1) begin
          if (q1.size() == 0) chk("p1_unexpected_data", p_val(1), -1);
          else begin
            hold1 = q1.pop_front();
            chk("p1_product", p_val(1), hold1);
          end
        end else chk("p1_hold", p_val(1), hold1);
      end
      prev1 = p_is_data(1);
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1;
    drive_null(0);
    drive_null(1);
    set_ki(0, 1'b0);
    set_ki(1, 1'b0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset_ko", ko_of(w), 1);
      chk("reset_p_null", p_is_null(w), 1);
      chk("reset_err", err_of(w), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 7, 7, 0, 49);
    run_op(0, 0, 7, 0, 0);

    // A complete, B bit2 NULL: no capture
    a0_r1 = 3'b101; a0_r0 = 3'b010; b0_r1 = 3'b011; b0_r0 = 3'b000; ki0 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("ko_partial", ko0, 1);
    end
    run_op(0, 5, 3, 0, 15);

    run_op(0, 6, 5, 6, 30);

    // Illegal code on A bit1
    a0_r1 = 3'b010; a0_r0 = 3'b010; b0_r1 = 3'b011; b0_r0 = 3'b100;
    @(negedge clk);
    chk("err_set", err0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("ko_illegal_no_capture", ko0, 1);
    end
    run_op(0, 2, 2, 0, 4);
    chk("err_sticky", err0, 1);

    run_op(1, -8, -1, 0, 8'h08);
    run_op(1, 7, -8, 0, 8'hC8);
    run_op(1, -8, -8, 0, 8'h40);
    run_op(1, 5, -3, 0, -1);
    run_op(1, 7, 7, 0, 49);

    // Reset while in MUL
    drive(0, 5, 6);
    ki0 = 1'b1;
    wait_ko(0, 1'b0, n);
    chk("ko_fall_before_rst", n, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ko", ko0, 1);
    chk("rst_mid_p_null", p_is_null(0), 1);
    chk("rst_mid_err", err0, 0);
    rst = 1'b0;
    drive_null(0);
    ki0 = 1'b0;
    @(negedge clk);
    run_op(0, 2, 3, 0, 6);

    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ncl_mult_seq.md
# ncl_mult_seq

Parametrised, clocked dual-rail (NCL-encoded) multiplier for A_W×B_W operands, unsigned or two's-complement. Operands and product use the team's dual-rail convention (rail1/rail0, all-zero = NULL) with four-phase DATA/NULL handshakes on both sides. Internally it is a sequential shift-add engine that issues one partial product per clock. It is the synchronous, width-generic successor to the fixed 3×3 NCL array multiplier, for FPGA prototypes and for mixed clocked/NCL pipelines.

## Interface
Parameters:
- A_W, 3, multiplicand width (≥2)
- B_W, 3, multiplier width (≥2)
- SIGNED, 0, 0 = unsigned, 1 = two's-complement operands and product
- P_W = A_W+B_W (derived, not overridable), product width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- a_r1, a_r0  in  A_W each  operand A, dual-rail
- b_r1, b_r0  in  B_W each  operand B, dual-rail
- ko  out  1  to producer: 1 = request DATA, 0 = request NULL
- p_r1, p_r0  out  P_W each  product, dual-rail, registered
- ki  in  1  from consumer: 1 = request DATA, 0 = request NULL
- err  out  1  sticky illegal-code flag (both rails high on any input bit)

## Operation
- Bit encodings: DATA0 = (r1,r0) = 01, DATA1 = 10, NULL = 00, 11 = illegal.
- Vector complete = every A and B bit is DATA. Vector null = every rail is 0.
- FSM states are IDLE, MUL, WAITKI, DATA, RTZ.
- IDLE: ko=1 and p is NULL. When the inputs are complete and no bit is illegal, capture A and B, clear the accumulator, set cnt=0, drive ko to 0, and go to MUL. Partially complete inputs cause a wait with no capture.
- MUL: each cycle, if B[cnt]=1, add A (shifted left by cnt, extended to P_W) to the accumulator. Extension is zero for unsigned and sign extension for SIGNED=1. When SIGNED=1 and cnt=B_W−1, subtract instead of add. The result is taken modulo 2^P_W. Leave MUL after cnt=B_W−1 and go to WAITKI.
- WAITKI: when ki=1, p takes the accumulator as DATA and the FSM goes to DATA. When ki=0, p stays NULL.
- DATA: p holds its value while ki=1. When ki=0, p goes to NULL and the FSM goes to RTZ.
- RTZ: when the inputs are null, drive ko to 1 and go to IDLE.
- Input NULL arriving early, in MUL/WAITKI/DATA, is legal. RTZ only samples the level.
- err: set in any state on any cycle where an input bit has both rails high. Cleared only by rst. While an illegal bit is present, IDLE does not capture.
- Captured operands are independent of input changes after capture.

## Timing
- Reset values: ko=1, p_r1=p_r0=0 (NULL), err=0, state=IDLE, cnt=0, accumulator=0.
- rst is asserted in any state, including mid-MUL: the above values hold from the next edge and the operation is discarded.
- Capture edge = E. ko=0 is visible after E.
- MUL occupies edges E+1 … E+B_W. WAITKI is entered after E+B_W.
- If ki=1 already, p is DATA after edge E+B_W+1. Latency = B_W+1 cycles from the capture edge.
- p goes NULL one edge after ki=0 is sampled in DATA.
- ko rises one edge after null inputs are sampled in RTZ. Minimum full cycle is E → next capture in B_W+4 edges.
- p_r1/p_r0 change only on clock edges. p never shows a mixed DATA/NULL vector.

## Structure
- Shared package ncl_pkg holds:
  - the dual_rail_logic struct (rail1, rail0)
  - the FSM state enum
  - functions dr_is_data(r1,r0) and dr_is_null(r1,r0)
  - a function that packs an unsigned value into (r1,r0) vectors
- One sub-module, ncl_dr_detect #(W). It takes r1/r0 vectors and produces combinational complete, null and illegal flags. It is instantiated once per operand.

## Test plan
- A_W=B_W=3, unsigned, A=7, B=7, ki=1: ko falls after E, p = 49 (p_r1=6'b110001, p_r0=6'b001110) after E+4. Drop inputs to NULL and ki to 0: p goes NULL, then ko=1.
- Partial input: A=5 complete, B bit2 NULL for 10 cycles: ko stays 1, no capture. When B=3 completes: p=15.
- Backpressure: ki held 0 for 6 cycles in WAITKI: p stays NULL. ki rises: p=DATA one edge later.
- Illegal code: a_r1[1]=a_r0[1]=1 in IDLE: err=1 next edge, no capture. err stays set after a legal DATA/NULL cycle until rst.
- SIGNED=1, A_W=B_W=4: A=−8, B=−1 → p=8'h08. A=7, B=−8 → p=8'hC8. A=−8, B=−8 → p=8'h40.
- rst asserted at E+2 during MUL: ko=1, p NULL, err=0 next edge. A fresh operation A=2, B=3 then yields p=6.
